call_stack_ctl: RTL and testbench
=================================

// Module: call_stack_ctl
// PURPOSE
//  Parametrised hardware call/return stack for the NeonFox PC unit; supersedes the fixed 16x32 call stack.
//  Holds return addresses pushed by call/interrupt and popped by ret; top of stack is always presented on data_out.
//  Adds occupancy tracking, full/empty status, sticky overflow/underflow flags, flush, and same-cycle replace.
//  Adds selectable wrap-vs-saturate overflow policy.
// PARAMETERS
//  WIDTH     32  entry width in bits (return address width)
//  DEPTH     16  number of entries; power of two, >= 2
//  OVF_WRAP   0  1: push when full overwrites oldest entry; 0: push when full is dropped
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  rst_n      in   1                 asynchronous, active-low reset
//  en         in   1                 operation enable (pipeline stall gate); en=0 freezes push/pop
//  push       in   1                 push data_in (qualified by en)
//  pop        in   1                 pop top entry (qualified by en)
//  flush      in   1                 empty the stack; independent of en
//  clr_err    in   1                 clear sticky overflow/underflow
//  data_in    in   WIDTH             value to push
//  data_out   out  WIDTH             current top of stack (registered)
//  count      out  $clog2(DEPTH)+1   number of valid entries, 0..DEPTH
//  empty      out  1                 count==0
//  full       out  1                 count==DEPTH
//  overflow   out  1                 sticky: push attempted while full
//  underflow  out  1                 sticky: pop attempted while empty
//  hwm        out  $clog2(DEPTH)+1   high-water mark (only with CSTACK_HWM_EN)
// BEHAVIOUR
//  Reset (rst_n=0, async): sp=0, count=0, data_out=0, overflow=underflow=0, hwm=0, state=S_EMPTY; memory not cleared.
//  Operations are decoded when en=1: push only=PUSH; pop only=POP; push&pop=REPLACE; neither=NOP.
//  PUSH: mem[sp]<=data_in; sp<=sp+1 (mod DEPTH); count+1; data_out<=data_in next cycle (latency 1).
//  POP: sp<=sp-1; count-1; data_out<=mem[sp-2] (new top, async read), or 0 if count becomes 0.
//  REPLACE: mem[sp-1]<=data_in; sp, count unchanged; data_out<=data_in. On empty, acts as PUSH; no underflow.
//  Full + PUSH, OVF_WRAP=0: no write, no sp/count change; overflow<=1.
//  Full + PUSH, OVF_WRAP=1: write and sp advance as normal (oldest lost); count stays DEPTH; overflow<=1; state->S_WRAPPED.
//  Empty + POP: no change to sp/count/data_out; underflow<=1.
//  flush: priority over all ops regardless of en; sp=0, count=0, data_out=0, state=S_EMPTY; sticky flags preserved.
//  clr_err: clears flags next cycle; a new error event in the same cycle wins (flag stays 1).
//  en=0: push/pop ignored entirely; no flag updates.
//  Wrap-around: sp is a log2(DEPTH)-bit pointer and wraps naturally; count is separate and saturates.
//  State machine (occupancy):
//   S_EMPTY   -PUSH/REPLACE-> S_ACTIVE (S_FULL if DEPTH reached)
//   S_ACTIVE  -PUSH to DEPTH-> S_FULL; -POP to 0-> S_EMPTY
//   S_FULL    -POP-> S_ACTIVE; -PUSH, OVF_WRAP=1-> S_WRAPPED
//   S_WRAPPED -POP-> S_ACTIVE (entries below lost base are stale but still returned); -PUSH-> S_WRAPPED
//   any       -flush-> S_EMPTY
//  empty/full are decoded from count, not registered separately.
// CONFIGURATION
//  Macro CSTACK_HWM_EN:
//   defined: hwm port exists; hwm<=max(hwm,count_next) every cycle; cleared by reset only (not flush/clr_err).
//   undefined: hwm port and register omitted; all other behaviour identical.
// STRUCTURE
//  Package call_stack_pkg: typedef enum logic[1:0] {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} cstack_op_e;
//   typedef enum logic[1:0] {S_EMPTY, S_ACTIVE, S_FULL, S_WRAPPED} cstack_state_e; helper function clog2-based width localparams.
//  Sub-module cstack_mem: DEPTH x WIDTH register-file, one synchronous write port, two async read ports
//   (sp-1, sp-2), ramstyle logic. The top level holds the pointer, count, FSM, flags and data_out register.
// TESTING
//  Reset, then PUSH 0xA,0xB,0xC (en=1) -> data_out 0xC, count 3; POP -> data_out 0xB, count 2.
//  DEPTH=16, OVF_WRAP=0: 17 pushes of 1..17 -> count 16, overflow=1, data_out 16; 16 pops drain 16..1.
//  OVF_WRAP=1: 18 pushes of 1..18 -> count 16, overflow=1, state S_WRAPPED; pops return 18..3.
//  Empty + pop -> underflow=1, data_out 0; clr_err together with a second empty pop -> underflow stays 1.
//  Push 0x5, then push&pop with 0x9 -> count 1, data_out 0x9; en=0 with push=1 -> nothing changes.
//  Push 3 entries, flush with en=0 -> count 0, empty=1, data_out 0; hwm=3 retained (CSTACK_HWM_EN); rst_n low mid-push clears all.

Source files
------------

// File: rtl/call_stack_pkg.sv
// Shared types and width helpers for the NeonFox call/return stack.
package call_stack_pkg;

   typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} cstack_op_e;
   typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL, S_WRAPPED} cstack_state_e;

   localparam int CSTACK_WIDTH_DEF = 32;
   localparam int CSTACK_DEPTH_DEF = 16;

   function automatic int cstack_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cstack_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cstack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, two asynchronous read ports.
module cstack_mem
   import call_stack_pkg::*;
#(
   parameter  int WIDTH = CSTACK_WIDTH_DEF,
   parameter  int DEPTH = CSTACK_DEPTH_DEF,
   localparam int AW    = cstack_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_top,
   input  logic [AW-1:0]    raddr_next,
   output logic [WIDTH-1:0] rdata_top,
   output logic [WIDTH-1:0] rdata_next
);

   (* ramstyle = "logic" *) logic [WIDTH-1:0] mem_r [DEPTH];

   // Write port; contents survive reset and flush on purpose.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata_top  = mem_r[raddr_top];
   assign rdata_next = mem_r[raddr_next];

endmodule

// File: rtl/call_stack_ctl.sv
// Parametrised call/return stack controller with occupancy, sticky error flags and flush.
// Optional high-water mark output enabled by macro CSTACK_HWM_EN.
module call_stack_ctl
   import call_stack_pkg::*;
#(
   parameter  int WIDTH    = CSTACK_WIDTH_DEF,
   parameter  int DEPTH    = CSTACK_DEPTH_DEF,
   parameter  int OVF_WRAP = 0,
   localparam int AW       = cstack_ptr_w(DEPTH),
   localparam int CW       = cstack_cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
`ifdef CSTACK_HWM_EN
   output logic [CW-1:0]    hwm,
`endif
   output logic             overflow,
   output logic             underflow
);

   cstack_op_e    op_s;
   cstack_state_e state_r, state_next_s;

   logic [AW-1:0]    sp_r, sp_next_s, waddr_s;
   logic [CW-1:0]    count_r, count_next_s;
   logic [WIDTH-1:0] dout_r, dout_next_s, rd_top_s, rd_next_s;
   logic             we_s, empty_s, full_s;
   logic             ovf_r, unf_r, ovf_ev_s, unf_ev_s;

   assign empty_s = (count_r == {CW{1'b0}});
   assign full_s  = (count_r == CW'(DEPTH));

   cstack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk        (clk),
      .we         (we_s),
      .waddr      (waddr_s),
      .wdata      (data_in),
      .raddr_top  (sp_r - AW'(1)),
      .raddr_next (sp_r - AW'(2)),
      .rdata_top  (rd_top_s),
      .rdata_next (rd_next_s)
   );

   // Operation decode, gated by the stall enable.
   always_comb begin
      op_s = OP_NOP;
      if (en) begin
         case ({push, pop})
            2'b10:   op_s = OP_PUSH;
            2'b01:   op_s = OP_POP;
            2'b11:   op_s = OP_REPLACE;
            default: op_s = OP_NOP;
         endcase
      end else begin
         op_s = OP_NOP;
      end
   end

   // Next-state, pointer, occupancy, write and top-of-stack logic.
   always_comb begin
      sp_next_s    = sp_r;
      count_next_s = count_r;
      we_s         = 1'b0;
      waddr_s      = sp_r;
      // Hold path re-reads the top entry, which always equals dout_r while non-empty.
      dout_next_s  = empty_s ? {WIDTH{1'b0}} : rd_top_s;
      ovf_ev_s     = 1'b0;
      unf_ev_s     = 1'b0;
      state_next_s = state_r;
      if (flush) begin
         sp_next_s    = {AW{1'b0}};
         count_next_s = {CW{1'b0}};
         dout_next_s  = {WIDTH{1'b0}};
         state_next_s = S_EMPTY;
      end else begin
         case (op_s)
            OP_PUSH: begin
               if (full_s) begin
                  ovf_ev_s = 1'b1;
                  if (OVF_WRAP != 0) begin
                     we_s         = 1'b1;
                     sp_next_s    = sp_r + AW'(1);
                     dout_next_s  = data_in;
                     state_next_s = S_WRAPPED;
                  end else begin
                     state_next_s = state_r;
                  end
               end else begin
                  we_s         = 1'b1;
                  sp_next_s    = sp_r + AW'(1);
                  count_next_s = count_r + CW'(1);
                  dout_next_s  = data_in;
                  state_next_s = (count_r == CW'(DEPTH - 1)) ? S_FULL : S_ACTIVE;
               end
            end
            OP_POP: begin
               if (empty_s) begin
                  unf_ev_s = 1'b1;
               end else begin
                  sp_next_s    = sp_r - AW'(1);
                  count_next_s = count_r - CW'(1);
                  dout_next_s  = (count_r == CW'(1)) ? {WIDTH{1'b0}} : rd_next_s;
                  state_next_s = (count_r == CW'(1)) ? S_EMPTY : S_ACTIVE;
               end
            end
            OP_REPLACE: begin
               we_s        = 1'b1;
               dout_next_s = data_in;
               if (empty_s) begin
                  sp_next_s    = sp_r + AW'(1);
                  count_next_s = CW'(1);
                  state_next_s = S_ACTIVE;
               end else begin
                  waddr_s = sp_r - AW'(1);
               end
            end
            default: begin
               state_next_s = state_r;
            end
         endcase
      end
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Pointer, count, top-of-stack and sticky flag registers; a new error beats clr_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_r    <= {AW{1'b0}};
         count_r <= {CW{1'b0}};
         dout_r  <= {WIDTH{1'b0}};
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         sp_r    <= sp_next_s;
         count_r <= count_next_s;
         dout_r  <= dout_next_s;
         ovf_r   <= ovf_ev_s | (ovf_r & ~clr_err);
         unf_r   <= unf_ev_s | (unf_r & ~clr_err);
      end
   end

`ifdef CSTACK_HWM_EN
   logic [CW-1:0] hwm_r;

   // High-water mark tracks the deepest post-operation occupancy; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_r <= {CW{1'b0}};
      end else if (count_next_s > hwm_r) begin
         hwm_r <= count_next_s;
      end else begin
         hwm_r <= hwm_r;
      end
   end

   assign hwm = hwm_r;
`endif

   assign data_out  = dout_r;
   assign count     = count_r;
   assign empty     = empty_s;
   assign full      = full_s;
   assign overflow  = ovf_r;
   assign underflow = unf_r;

endmodule

// File: tb/tb_call_stack_ctl.sv
// Self-checking bench: saturate and wrap instances against an array-based stack model.
module tb_call_stack_ctl;

   localparam int W  = 32;
   localparam int D  = 16;
   localparam int CW = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         en, push, pop, flush, clr_err;
   logic [W-1:0] din;

   logic [W-1:0]  dout_n, dout_w;
   logic [CW-1:0] cnt_n, cnt_w;
   logic          emp_n, emp_w, full_n, full_w, ovf_n, ovf_w, unf_n, unf_w;
`ifdef CSTACK_HWM_EN
   logic [CW-1:0] hwm_n, hwm_w;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: entry 0 is the oldest surviving entry, [mcnt-1] the top.
   logic [W-1:0] ent  [2][D];
   int           mcnt [2];
   bit           movf [2];
   bit           munf [2];
   int           mhwm [2];

   always #5 clk = ~clk;

   call_stack_ctl #(.WIDTH(W), .DEPTH(D), .OVF_WRAP(0)) u_nw (
      .clk(clk), .rst_n(rst_n), .en(en), .push(push), .pop(pop), .flush(flush),
      .clr_err(clr_err), .data_in(din), .data_out(dout_n), .count(cnt_n),
      .empty(emp_n), .full(full_n),
`ifdef CSTACK_HWM_EN
      .hwm(hwm_n),
`endif
      .overflow(ovf_n), .underflow(unf_n));

   call_stack_ctl #(.WIDTH(W), .DEPTH(D), .OVF_WRAP(1)) u_wr (
      .clk(clk), .rst_n(rst_n), .en(en), .push(push), .pop(pop), .flush(flush),
      .clr_err(clr_err), .data_in(din), .data_out(dout_w), .count(cnt_w),
      .empty(emp_w), .full(full_w),
`ifdef CSTACK_HWM_EN
      .hwm(hwm_w),
`endif
      .overflow(ovf_w), .underflow(unf_w));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_top(input int m);
      if (mcnt[m] == 0) return '0;
      return ent[m][mcnt[m]-1];
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mcnt[m] = 0; movf[m] = 1'b0; munf[m] = 1'b0; mhwm[m] = 0;
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         bit ov = 1'b0;
         bit un = 1'b0;
         if (flush) begin
            mcnt[m] = 0;
         end else if (en && push && pop && mcnt[m] > 0) begin
            ent[m][mcnt[m]-1] = din;
         end else if (en && push) begin
            if (mcnt[m] < D) begin
               ent[m][mcnt[m]] = din;
               mcnt[m]++;
            end else begin
               ov = 1'b1;
               if (m == 1) begin
                  for (int k = 0; k < D - 1; k++) ent[m][k] = ent[m][k+1];
                  ent[m][D-1] = din;
               end
            end
         end else if (en && pop) begin
            if (mcnt[m] > 0) mcnt[m]--;
            else un = 1'b1;
         end
         movf[m] = ov ? 1'b1 : (clr_err ? 1'b0 : movf[m]);
         munf[m] = un ? 1'b1 : (clr_err ? 1'b0 : munf[m]);
         if (mcnt[m] > mhwm[m]) mhwm[m] = mcnt[m];
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".nw.dout"}, 64'(dout_n), 64'(exp_top(0)));
      chk({tag, ".nw.count"}, 64'(cnt_n), 64'(mcnt[0]));
      chk({tag, ".nw.empty"}, 64'(emp_n), 64'(mcnt[0] == 0));
      chk({tag, ".nw.full"}, 64'(full_n), 64'(mcnt[0] == D));
      chk({tag, ".nw.ovf"}, 64'(ovf_n), 64'(movf[0]));
      chk({tag, ".nw.unf"}, 64'(unf_n), 64'(munf[0]));
      chk({tag, ".wr.dout"}, 64'(dout_w), 64'(exp_top(1)));
      chk({tag, ".wr.count"}, 64'(cnt_w), 64'(mcnt[1]));
      chk({tag, ".wr.empty"}, 64'(emp_w), 64'(mcnt[1] == 0));
      chk({tag, ".wr.full"}, 64'(full_w), 64'(mcnt[1] == D));
      chk({tag, ".wr.ovf"}, 64'(ovf_w), 64'(movf[1]));
      chk({tag, ".wr.unf"}, 64'(unf_w), 64'(munf[1]));
`ifdef CSTACK_HWM_EN
      chk({tag, ".nw.hwm"}, 64'(hwm_n), 64'(mhwm[0]));
      chk({tag, ".wr.hwm"}, 64'(hwm_w), 64'(mhwm[1]));
`endif
   endtask

   task automatic cyc(input bit e, input bit pu, input bit po, input bit fl, input bit ce,
                      input logic [W-1:0] d, input string tag);
      en = e; push = pu; pop = po; flush = fl; clr_err = ce; din = d;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      en = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();

      // Basic push/pop
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA, "push_a");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB, "push_b");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, "push_c");
      chk("abc.dout", 64'(dout_n), 64'h0000_000C);
      chk("abc.count", 64'(cnt_n), 64'd3);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "pop_c");
      chk("pop.dout", 64'(dout_n), 64'h0000_000B);
      chk("pop.count", 64'(cnt_n), 64'd2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "flush1");

      // 17 pushes: saturate drops the last, wrap loses the oldest
      for (int i = 1; i <= 17; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W'(i), "fill17");
      chk("sat.count", 64'(cnt_n), 64'd16);
      chk("sat.ovf", 64'(ovf_n), 64'd1);
      chk("sat.dout", 64'(dout_n), 64'd16);
      for (int k = 0; k < 16; k++) begin
         chk("sat.drain", 64'(dout_n), 64'(16 - k));
         cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "drain17");
      end
      chk("sat.empty", 64'(emp_n), 64'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, "flush_clr");

      for (int i = 1; i <= 18; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W'(i), "fill18");
      chk("wrap.count", 64'(cnt_w), 64'd16);
      chk("wrap.ovf", 64'(ovf_w), 64'd1);
      for (int k = 0; k < 16; k++) begin
         chk("wrap.drain", 64'(dout_w), 64'(18 - k));
         cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "drain18");
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, "flush_clr2");

      // Underflow and clear-vs-new-event priority
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "unf1");
      chk("unf.flag", 64'(unf_n), 64'd1);
      chk("unf.dout", 64'(dout_n), 64'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, "unf_clr");
      chk("unf.sticky", 64'(unf_n), 64'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "clr_only");
      chk("unf.cleared", 64'(unf_n), 64'd0);

      // Replace and stall
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, "push5");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h9, "repl9");
      chk("repl.count", 64'(cnt_n), 64'd1);
      chk("repl.dout", 64'(dout_n), 64'h9);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7, "stall");
      chk("stall.count", 64'(cnt_n), 64'd1);
      chk("stall.dout", 64'(dout_n), 64'h9);

      // Flush while stalled keeps the high-water mark
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W'(32'h40 + i), "push3");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "flush_en0");
      chk("fl.count", 64'(cnt_n), 64'd0);
      chk("fl.empty", 64'(emp_n), 64'd1);
      chk("fl.dout", 64'(dout_n), 64'd0);
`ifdef CSTACK_HWM_EN
      chk("fl.hwm", 64'(hwm_n), 64'd3);
`endif

      // Asynchronous reset in the middle of pushing
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, "pre_rst");
      en = 1'b1; push = 1'b1; din = 32'h88;
      @(posedge clk);
      model_step();
      #2 rst_n = 1'b0;
      push = 1'b0;
      model_reset();
      #1;
      check_all("mid_rst");
      chk("mid_rst.count", 64'(cnt_n), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         cyc(($urandom % 8) != 0, ($urandom % 2) == 0, ($urandom % 5) < 2,
             ($urandom % 64) == 0, ($urandom % 16) == 0, W'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
